// File: rtl/gf_mul_arbiter_pkg.sv
// Shared declarations for the GF multiplier arbiter slice.
//   MIN_NUM_REQ / MAX_NUM_REQ : legal requester count range.
//   rr_wrap()                 : wraps an index that may have run one past n.
package gf_mul_arbiter_pkg;

  localparam int unsigned MIN_NUM_REQ = 32'd2;
  localparam int unsigned MAX_NUM_REQ = 32'd8;

  // Indices handed in are always below 2*n, so one subtraction is a full modulo.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    if (idx >= n) begin
      return idx - n;
    end else begin
      return idx;
    end
  endfunction

endpackage

// File: rtl/generic_mul.sv
// Combinational GF(2^BIT_WIDTH) multiplier in polynomial basis.
//   a_i, b_i : operands
//   c_o      : product a_i * b_i
// Field polynomials: x+1 (W=1), x^2+x+1 (W=2), x^4+x+1 (W=4).
module generic_mul #(
  parameter int unsigned BIT_WIDTH = 4
) (
  input  logic [BIT_WIDTH-1:0] a_i,
  input  logic [BIT_WIDTH-1:0] b_i,
  output logic [BIT_WIDTH-1:0] c_o
);

  // All three supported polynomials share the low-order pattern ...0011, so
  // one constant sliced to the field width gives the reduction term.
  localparam logic [3:0]           POLY_ALL = 4'b0011;
  localparam logic [BIT_WIDTH-1:0] POLY     = POLY_ALL[BIT_WIDTH-1:0];

  if ((BIT_WIDTH != 32'd1) && (BIT_WIDTH != 32'd2) && (BIT_WIDTH != 32'd4)) begin : g_width_check
    $error("generic_mul: unsupported BIT_WIDTH %0d", BIT_WIDTH);
  end

  logic [BIT_WIDTH-1:0] acc_s;

  // Horner-style shift-and-add, MSB of b first, reducing after every shift.
  always_comb begin
    acc_s = {BIT_WIDTH{1'b0}};
    for (int i = BIT_WIDTH - 1; i >= 0; i--) begin
      if (acc_s[BIT_WIDTH-1]) begin
        acc_s = (acc_s << 1) ^ POLY;
      end else begin
        acc_s = acc_s << 1;
      end
      if (b_i[i]) begin
        acc_s = acc_s ^ a_i;
      end else begin
        acc_s = acc_s;
      end
    end
    c_o = acc_s;
  end

endmodule

// File: rtl/gf_mul_arbiter_rr_arbiter.sv
// Round-robin arbiter with its own rotating priority pointer.
//   in_clock, in_reset_n : clock, synchronous active-low reset
//   req_i                : request vector
//   en_i                 : grants may only fire while high
//   grant_o              : one-hot grant (zero when nothing granted)
//   grant_idx_o          : index of the granted requester
//   grant_valid_o        : a grant fires this cycle
module rr_arbiter
  import gf_mul_arbiter_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic          in_clock,
  input  logic          in_reset_n,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          grant_valid_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] idx_s;
  logic          found_s;

  // Search upward from the pointer, wrapping, and take the first request.
  always_comb begin
    grant_o     = {N{1'b0}};
    grant_idx_o = {IW{1'b0}};
    found_s     = 1'b0;
    idx_s       = {IW{1'b0}};
    if (en_i) begin
      for (int unsigned off = 32'd0; off < N; off++) begin
        idx_s = IW'(rr_wrap(32'(ptr_q) + off, N));
        if (!found_s && req_i[idx_s]) begin
          found_s        = 1'b1;
          grant_idx_o    = idx_s;
          grant_o[idx_s] = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      found_s = 1'b0;
    end
    grant_valid_o = found_s;
  end

  // Pointer moves just past the winner, and only when a grant fires.
  always_comb begin
    if (grant_valid_o) begin
      ptr_d = IW'(rr_wrap(32'(grant_idx_o) + 32'd1, N));
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge in_clock) begin
    if (!in_reset_n) begin
      ptr_q <= {IW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/gf_mul_arbiter.sv
// Shares one GF(2^BIT_WIDTH) multiplier among NUM_REQ requesters.
//   in_clock, in_reset_n          : clock, synchronous active-low reset
//   in_req_valid / out_req_ready  : per-requester handshake (ready one-hot or 0)
//   in_req_a, in_req_b            : packed operands, requester i at [i*BIT_WIDTH +: BIT_WIDTH]
//   out_rsp_valid / in_rsp_ready  : common response handshake
//   out_rsp_c, out_rsp_id         : registered product and issuing requester id
module gf_mul_arbiter
  import gf_mul_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BIT_WIDTH = 4,
  parameter int unsigned ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                         in_clock,
  input  logic                         in_reset_n,
  input  logic [NUM_REQ-1:0]           in_req_valid,
  output logic [NUM_REQ-1:0]           out_req_ready,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] in_req_a,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] in_req_b,
  output logic                         out_rsp_valid,
  input  logic                         in_rsp_ready,
  output logic [BIT_WIDTH-1:0]         out_rsp_c,
  output logic [ID_WIDTH-1:0]          out_rsp_id
);

  typedef logic [ID_WIDTH-1:0] req_id_t;

  if ((NUM_REQ < MIN_NUM_REQ) || (NUM_REQ > MAX_NUM_REQ)) begin : g_num_req_check
    $error("gf_mul_arbiter: NUM_REQ %0d outside 2..8", NUM_REQ);
  end

  logic                 rsp_valid_q, rsp_valid_d;
  logic [BIT_WIDTH-1:0] rsp_c_q, rsp_c_d;
  req_id_t              rsp_id_q, rsp_id_d;

  logic                 free_s;
  logic                 arb_en_s;
  logic [NUM_REQ-1:0]   grant_s;
  req_id_t              grant_idx_s;
  logic                 grant_valid_s;
  logic [BIT_WIDTH-1:0] mul_a_s, mul_b_s, mul_c_s;

  // The slot is free when empty or being drained this cycle. Reset also
  // blocks grants so no requester sees an acceptance that gets discarded.
  assign free_s   = !rsp_valid_q || in_rsp_ready;
  assign arb_en_s = free_s && in_reset_n;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .in_clock      (in_clock),
    .in_reset_n    (in_reset_n),
    .req_i         (in_req_valid),
    .en_i          (arb_en_s),
    .grant_o       (grant_s),
    .grant_idx_o   (grant_idx_s),
    .grant_valid_o (grant_valid_s)
  );

  assign out_req_ready = grant_s;

  // AND-OR operand mux driven by the one-hot grant.
  always_comb begin
    mul_a_s = {BIT_WIDTH{1'b0}};
    mul_b_s = {BIT_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      mul_a_s = mul_a_s | (grant_s[i] ? in_req_a[i*BIT_WIDTH +: BIT_WIDTH] : {BIT_WIDTH{1'b0}});
      mul_b_s = mul_b_s | (grant_s[i] ? in_req_b[i*BIT_WIDTH +: BIT_WIDTH] : {BIT_WIDTH{1'b0}});
    end
  end

  generic_mul #(.BIT_WIDTH(BIT_WIDTH)) u_mul (
    .a_i (mul_a_s),
    .b_i (mul_b_s),
    .c_o (mul_c_s)
  );

  // Result slot next state: load on grant, empty on drain, otherwise hold.
  always_comb begin
    if (grant_valid_s) begin
      rsp_valid_d = 1'b1;
      rsp_c_d     = mul_c_s;
      rsp_id_d    = grant_idx_s;
    end else if (in_rsp_ready) begin
      rsp_valid_d = 1'b0;
      rsp_c_d     = rsp_c_q;
      rsp_id_d    = rsp_id_q;
    end else begin
      rsp_valid_d = rsp_valid_q;
      rsp_c_d     = rsp_c_q;
      rsp_id_d    = rsp_id_q;
    end
  end

  // Result slot registers.
  always_ff @(posedge in_clock) begin
    if (!in_reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_c_q     <= {BIT_WIDTH{1'b0}};
      rsp_id_q    <= {ID_WIDTH{1'b0}};
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_c_q     <= rsp_c_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign out_rsp_valid = rsp_valid_q;
  assign out_rsp_c     = rsp_c_q;
  assign out_rsp_id    = rsp_id_q;

endmodule
